// File: rtl/icache_pkg.sv
// Shared widths, constants and FSM state encoding for the instruction cache.
package icache_pkg;

    localparam int ADDR              = 32;
    localparam int INSTRLEN          = 32;
    localparam int ICACHE_INDEX_BITS = 8;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [31:0] NULL32 = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage : icache_pkg

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid flops plus tag/data arrays.
// Reads are combinational; a single write port fills one line per cycle.
module icache_array #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_W      = 22,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data carry no reset; stale contents are masked by the valid bit.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule : icache_array

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between fetch and the memory controller.
//   state | meaning
//   IDLE  | serve hits in one cycle, launch a read on a miss
//   MISS  | read outstanding; wait for mem_success, fill line, answer unless flushed
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_W     = ADDR,
    parameter int DATA_W     = INSTRLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              ifetch_valid,
    input  logic [ADDR_W-1:0] ifetch_addr,
    output logic              ifetch_ready,
    output logic [DATA_W-1:0] ifetch_instr,
    output logic              mem_read_signal,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_instr,
    input  logic              mem_success
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    icache_state_t         state, state_nxt;
    logic                  discard, discard_nxt;
    logic [INDEX_BITS-1:0] miss_index, miss_index_nxt;
    logic [TAG_W-1:0]      miss_tag, miss_tag_nxt;
    logic                  ifetch_ready_nxt;
    logic [DATA_W-1:0]     ifetch_instr_nxt;
    logic                  mem_read_signal_nxt;
    logic [ADDR_W-1:0]     mem_addr_nxt;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_W-1:0]     rd_data;
    logic                  hit;
    logic                  fill;
    logic                  unused_addr_bits;

    assign req_index        = ifetch_addr[INDEX_BITS+1:2];
    assign req_tag          = ifetch_addr[ADDR_W-1:INDEX_BITS+2];
    assign unused_addr_bits = ^ifetch_addr[1:0];
    assign hit              = rd_valid && (rd_tag == req_tag);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill && rdy),
        .wr_index (miss_index),
        .wr_tag   (miss_tag),
        .wr_data  (mem_instr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            discard         <= FALSE;
            miss_index      <= '0;
            miss_tag        <= '0;
            ifetch_ready    <= FALSE;
            ifetch_instr    <= NULL32;
            mem_read_signal <= FALSE;
            mem_addr        <= NULL32;
        end else if (rdy) begin
            state           <= state_nxt;
            discard         <= discard_nxt;
            miss_index      <= miss_index_nxt;
            miss_tag        <= miss_tag_nxt;
            ifetch_ready    <= ifetch_ready_nxt;
            ifetch_instr    <= ifetch_instr_nxt;
            mem_read_signal <= mem_read_signal_nxt;
            mem_addr        <= mem_addr_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        discard_nxt         = discard;
        miss_index_nxt      = miss_index;
        miss_tag_nxt        = miss_tag;
        ifetch_ready_nxt    = FALSE;
        ifetch_instr_nxt    = ifetch_instr;
        mem_read_signal_nxt = mem_read_signal;
        mem_addr_nxt        = mem_addr;
        fill                = FALSE;

        case (state)
            IDLE: begin
                if (!clr && ifetch_valid) begin
                    if (hit) begin
                        ifetch_instr_nxt = rd_data;
                        ifetch_ready_nxt = TRUE;
                    end else begin
                        miss_index_nxt      = req_index;
                        miss_tag_nxt        = req_tag;
                        mem_addr_nxt        = {ifetch_addr[ADDR_W-1:2], 2'b00};
                        mem_read_signal_nxt = TRUE;
                        discard_nxt         = FALSE;
                        state_nxt           = MISS;
                    end
                end
            end
            MISS: begin
                if (clr) begin
                    discard_nxt = TRUE;
                end
                // The controller read cannot be aborted, so a flushed fill still lands.
                if (mem_success) begin
                    fill                = TRUE;
                    mem_read_signal_nxt = FALSE;
                    mem_addr_nxt        = NULL32;
                    state_nxt           = IDLE;
                    if (!discard && !clr) begin
                        ifetch_instr_nxt = mem_instr;
                        ifetch_ready_nxt = TRUE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : icache

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written flush/stall/reset
// sequences, and randomized fetches against a line-level reference model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        ifetch_valid;
    logic [31:0] ifetch_addr;
    logic        ifetch_ready;
    logic [31:0] ifetch_instr;
    logic        mem_read_signal;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        mem_success;

    int total = 0;
    int bad   = 0;

    icache dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clr             (clr),
        .ifetch_valid    (ifetch_valid),
        .ifetch_addr     (ifetch_addr),
        .ifetch_ready    (ifetch_ready),
        .ifetch_instr    (ifetch_instr),
        .mem_read_signal (mem_read_signal),
        .mem_addr        (mem_addr),
        .mem_instr       (mem_instr),
        .mem_success     (mem_success)
    );

    always #5 clk = ~clk;

    // Reference model: one entry per line, 256 lines, tag = addr[31:10].
    bit          m_valid [256];
    logic [21:0] m_tag   [256];
    logic [31:0] m_data  [256];

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic        exp_miss;
        logic [31:0] exp_instr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0004) return 32'h00A0_0093;
        if (w == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[9:2]);
        return m_valid[idx] && (m_tag[idx] == a[31:10]);
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx          = int'(a[9:2]);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[31:10];
        m_data[idx]  = d;
    endfunction

    task automatic do_reset();
        rst          = 1'b0;
        rdy          = 1'b0;
        clr          = 1'b0;
        ifetch_valid = 1'b0;
        ifetch_addr  = 32'h0;
        mem_success  = 1'b0;
        mem_instr    = 32'h0;
        step();
        step();
        rst = 1'b1;
        rdy = 1'b1;
        model_clear();
    endtask

    // Hold a request until ifetch_ready; act as memory controller with 'lat' wait cycles.
    task automatic fetch(input logic [31:0] addr, input int lat,
                         output logic saw_miss, output logic [31:0] instr, output int cycles);
        bit got;
        int wait_cnt;
        got          = 1'b0;
        wait_cnt     = 0;
        saw_miss     = 1'b0;
        instr        = 32'h0;
        cycles       = 0;
        ifetch_valid = 1'b1;
        ifetch_addr  = addr;
        while (!got && cycles < 40) begin
            step();
            cycles++;
            mem_success = 1'b0;
            if (ifetch_ready) begin
                got   = 1'b1;
                instr = ifetch_instr;
                chk("rd_low_on_resp", {31'b0, mem_read_signal}, 32'h0);
            end else if (mem_read_signal) begin
                saw_miss = 1'b1;
                chk("miss_mem_addr", mem_addr, {addr[31:2], 2'b00});
                if (wait_cnt == lat) begin
                    mem_success = 1'b1;
                    mem_instr   = mem_word(addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
        ifetch_valid = 1'b0;
        mem_success  = 1'b0;
        if (!got) chk("fetch_timeout", 32'h0, 32'h1);
    endtask

    vec_t        vecs [12];
    logic        saw_miss;
    logic [31:0] instr;
    int          cycles;

    initial begin
        vecs[0]  = '{32'h0000_0004, 2, 1'b1, 32'h00A0_0093};
        vecs[1]  = '{32'h0000_0004, 0, 1'b0, 32'h00A0_0093};
        vecs[2]  = '{32'h0000_0007, 0, 1'b0, 32'h00A0_0093};
        vecs[3]  = '{32'h0000_0404, 1, 1'b1, mem_word(32'h0000_0404)};
        vecs[4]  = '{32'h0000_0004, 3, 1'b1, 32'h00A0_0093};
        vecs[5]  = '{32'h0000_0404, 0, 1'b1, mem_word(32'h0000_0404)};
        vecs[6]  = '{32'h0000_03FC, 0, 1'b1, mem_word(32'h0000_03FC)};
        vecs[7]  = '{32'h0000_03FC, 0, 1'b0, mem_word(32'h0000_03FC)};
        vecs[8]  = '{32'hFFFF_FFFC, 1, 1'b1, mem_word(32'hFFFF_FFFC)};
        vecs[9]  = '{32'h0000_03FC, 0, 1'b1, mem_word(32'h0000_03FC)};
        vecs[10] = '{32'h0000_0008, 4, 1'b1, mem_word(32'h0000_0008)};
        vecs[11] = '{32'h0000_0008, 0, 1'b0, mem_word(32'h0000_0008)};

        do_reset();
        chk("rst_ready", {31'b0, ifetch_ready}, 32'h0);
        chk("rst_instr", ifetch_instr, 32'h0);
        chk("rst_rd", {31'b0, mem_read_signal}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);

        for (int i = 0; i < 12; i++) begin
            fetch(vecs[i].addr, vecs[i].lat, saw_miss, instr, cycles);
            chk($sformatf("vec%0d_miss", i), {31'b0, saw_miss}, {31'b0, vecs[i].exp_miss});
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_lat", i), cycles, vecs[i].exp_miss ? 2 + vecs[i].lat : 1);
            step();
            chk($sformatf("vec%0d_single_pulse", i), {31'b0, ifetch_ready}, 32'h0);
        end

        // Flush during miss: fill lands, no delivery, later hit returns filled word.
        do_reset();
        ifetch_valid = 1'b1; ifetch_addr = 32'h10;
        step();
        chk("flush_rd", {31'b0, mem_read_signal}, 32'h1);
        clr = 1'b1; ifetch_valid = 1'b0;
        step();
        clr = 1'b0;
        chk("flush_rd_hold", {31'b0, mem_read_signal}, 32'h1);
        chk("flush_addr_hold", mem_addr, 32'h10);
        mem_success = 1'b1; mem_instr = 32'hDEAD_BEEF;
        step();
        mem_success = 1'b0;
        chk("flush_no_ready", {31'b0, ifetch_ready}, 32'h0);
        chk("flush_rd_drop", {31'b0, mem_read_signal}, 32'h0);
        chk("flush_addr_zero", mem_addr, 32'h0);
        step();
        chk("flush_no_ready2", {31'b0, ifetch_ready}, 32'h0);
        fetch(32'h10, 0, saw_miss, instr, cycles);
        chk("flush_rehit_miss", {31'b0, saw_miss}, 32'h0);
        chk("flush_rehit_instr", instr, 32'hDEAD_BEEF);
        chk("flush_rehit_lat", cycles, 1);

        // clr coinciding with mem_success.
        ifetch_valid = 1'b1; ifetch_addr = 32'h20;
        step();
        chk("clrsucc_rd", {31'b0, mem_read_signal}, 32'h1);
        ifetch_valid = 1'b0; clr = 1'b1; mem_success = 1'b1; mem_instr = mem_word(32'h20);
        step();
        clr = 1'b0; mem_success = 1'b0;
        chk("clrsucc_no_ready", {31'b0, ifetch_ready}, 32'h0);
        chk("clrsucc_rd_drop", {31'b0, mem_read_signal}, 32'h0);
        fetch(32'h20, 0, saw_miss, instr, cycles);
        chk("clrsucc_hit", {31'b0, saw_miss}, 32'h0);
        chk("clrsucc_instr", instr, mem_word(32'h20));

        // clr in IDLE suppresses a hit.
        ifetch_valid = 1'b1; ifetch_addr = 32'h20; clr = 1'b1;
        step();
        clr = 1'b0; ifetch_valid = 1'b0;
        chk("idleclr_no_ready", {31'b0, ifetch_ready}, 32'h0);
        chk("idleclr_no_rd", {31'b0, mem_read_signal}, 32'h0);
        step();

        // Stall around a hit.
        ifetch_valid = 1'b1; ifetch_addr = 32'h20; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stallhit_frozen", {31'b0, ifetch_ready}, 32'h0);
        end
        rdy = 1'b1;
        step();
        chk("stallhit_ready", {31'b0, ifetch_ready}, 32'h1);
        chk("stallhit_instr", ifetch_instr, mem_word(32'h20));
        ifetch_valid = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stallhit_hold", {31'b0, ifetch_ready}, 32'h1);
        end
        rdy = 1'b1;
        step();
        chk("stallhit_one_pulse", {31'b0, ifetch_ready}, 32'h0);

        // Stall around mem_success.
        ifetch_valid = 1'b1; ifetch_addr = 32'h30;
        step();
        chk("stallmiss_rd", {31'b0, mem_read_signal}, 32'h1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stallmiss_rd_hold", {31'b0, mem_read_signal}, 32'h1);
            chk("stallmiss_addr_hold", mem_addr, 32'h30);
        end
        rdy = 1'b1; mem_success = 1'b1; mem_instr = mem_word(32'h30);
        step();
        mem_success = 1'b0; ifetch_valid = 1'b0; rdy = 1'b0;
        chk("stallmiss_ready", {31'b0, ifetch_ready}, 32'h1);
        chk("stallmiss_instr", ifetch_instr, mem_word(32'h30));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stallmiss_hold", {31'b0, ifetch_ready}, 32'h1);
            chk("stallmiss_rd_low", {31'b0, mem_read_signal}, 32'h0);
        end
        rdy = 1'b1;
        step();
        chk("stallmiss_one_pulse", {31'b0, ifetch_ready}, 32'h0);

        // Reset mid-miss.
        fetch(32'h4, 0, saw_miss, instr, cycles);
        chk("rstmid_prefill", {31'b0, saw_miss}, 32'h1);
        ifetch_valid = 1'b1; ifetch_addr = 32'h40;
        step();
        chk("rstmid_rd", {31'b0, mem_read_signal}, 32'h1);
        rst = 1'b0; ifetch_valid = 1'b0;
        step();
        rst = 1'b1;
        chk("rstmid_rd_drop", {31'b0, mem_read_signal}, 32'h0);
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_instr", ifetch_instr, 32'h0);
        mem_success = 1'b1; mem_instr = 32'h1234_5678;
        step();
        mem_success = 1'b0;
        chk("stray_no_ready", {31'b0, ifetch_ready}, 32'h0);
        chk("stray_no_rd", {31'b0, mem_read_signal}, 32'h0);
        fetch(32'h4, 0, saw_miss, instr, cycles);
        chk("rstmid_refetch_miss", {31'b0, saw_miss}, 32'h1);
        chk("rstmid_refetch_instr", instr, 32'h00A0_0093);

        // Randomized fetches against the line model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [21:0] t;
            bit          exp_hit;
            int          lat;
            case ($urandom_range(0, 3))
                0: t = 22'h0;
                1: t = 22'h1;
                2: t = 22'h2A5;
                default: t = 22'h3F_FFFF;
            endcase
            a = {t, 5'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            lat = $urandom_range(0, 3);
            exp_hit = model_hit(a);
            fetch(a, lat, saw_miss, instr, cycles);
            chk("rand_miss", {31'b0, saw_miss}, {31'b0, !exp_hit});
            chk("rand_instr", instr, exp_hit ? m_data[int'(a[9:2])] : mem_word(a));
            chk("rand_lat", cycles, exp_hit ? 1 : 2 + lat);
            if (!exp_hit) model_fill(a, mem_word(a));
            if ($urandom_range(0, 3) == 0) begin
                mem_success = 1'b1; mem_instr = $urandom;
                step();
                mem_success = 1'b0;
                chk("rand_stray_ignored", {31'b0, ifetch_ready | mem_read_signal}, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_icache
